// File: rtl/small_lpf_mc.sv
// small_lpf_mc: time-multiplexed single-pole IIR low-pass filter.
// Each sample carries a channel tag, and each channel keeps its own accumulator.
// Two-stage pipeline: S1 reads the channel state, S2 updates it and registers the result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear of every channel state; wins over in_valid
//   in_valid/in_chan/in_data/shift_sel   sample, its channel, and filter shift k
//   out_valid/out_chan/out_data          filtered sample, 2 cycles after acceptance
module small_lpf_mc #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FILT_BITS = 5,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SIGNED    = 0,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned SW = $clog2(FILT_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    shift_sel,
    output logic             out_valid,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned A     = WIDTH + FILT_BITS + 1;
    localparam int unsigned NSLOT = 1 << CW;

    // State storage is sized to the full tag range so any in_chan indexes safely;
    // slots at or above CHANNELS are never written.
    logic signed [A-1:0] acc [NSLOT];

    logic                s1_valid;
    logic [CW-1:0]       s1_chan;
    logic [WIDTH-1:0]    s1_data;
    logic [SW-1:0]       s1_k;
    logic signed [A-1:0] s1_acc;

    logic [SW-1:0]       k_c;
    logic                accept_c;
    logic signed [A-1:0] rd_acc_c;
    logic signed [A-1:0] x_c;
    logic signed [A-1:0] diff_c;
    logic signed [A-1:0] step_c;
    logic signed [A-1:0] acc_new_c;

    // S2 datapath: acc + ((X - acc) >>> k). The difference always fits in A bits.
    always_comb begin
        if (SIGNED != 0) begin
            x_c = {s1_data[WIDTH-1], s1_data, {FILT_BITS{1'b0}}};
        end else begin
            x_c = {1'b0, s1_data, {FILT_BITS{1'b0}}};
        end
        diff_c    = x_c - s1_acc;
        step_c    = diff_c >>> s1_k;
        acc_new_c = s1_acc + step_c;
    end

    // S1 input qualification, shift clamp and state read with S2 forwarding.
    always_comb begin
        k_c = shift_sel;
        if (32'(shift_sel) > FILT_BITS) begin
            k_c = SW'(FILT_BITS);
        end
        accept_c = in_valid && !clr && (32'(in_chan) < CHANNELS);
        rd_acc_c = acc[in_chan];
        if (s1_valid && (s1_chan == in_chan)) begin
            rd_acc_c = acc_new_c;
        end
    end

    // Per-channel accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                acc[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                acc[i] <= '0;
            end
        end else if (s1_valid) begin
            acc[s1_chan] <= acc_new_c;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_chan  <= '0;
            s1_data  <= '0;
            s1_k     <= '0;
            s1_acc   <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_chan <= in_chan;
                s1_data <= in_data;
                s1_k    <= k_c;
                s1_acc  <= rd_acc_c;
            end
        end
    end

    // Stage 2 output registers; data/chan hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid && !clr;
            if (s1_valid && !clr) begin
                out_chan <= s1_chan;
                out_data <= acc_new_c[FILT_BITS +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_small_lpf_mc.sv
// Bench for small_lpf_mc: an unsigned 4-channel instance and a signed 3-channel
// instance share the same stimulus; a behavioural model queues expected outputs.
module tb_small_lpf_mc;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [1:0] in_chan;
    logic [7:0] in_data;
    logic [2:0] shift_sel;

    logic       out_valid_u, out_valid_s;
    logic [1:0] out_chan_u, out_chan_s;
    logic [7:0] out_data_u, out_data_s;

    small_lpf_mc #(.WIDTH(8), .FILT_BITS(5), .CHANNELS(4), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_chan(in_chan),
        .in_data(in_data), .shift_sel(shift_sel), .out_valid(out_valid_u),
        .out_chan(out_chan_u), .out_data(out_data_u)
    );

    small_lpf_mc #(.WIDTH(8), .FILT_BITS(5), .CHANNELS(3), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_chan(in_chan),
        .in_data(in_data), .shift_sel(shift_sel), .out_valid(out_valid_s),
        .out_chan(out_chan_s), .out_data(out_data_s)
    );

    typedef struct {
        int chan;
        int data;
        int due;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];
    int   acc_u[4];
    int   acc_s[3];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   mono_mode;
    int   last1;
    bit   log_on;
    int   log_ch;
    int   logq[$];
    int   ref_q[$];
    int   vals[10] = '{200, 13, 255, 0, 90, 90, 1, 170, 64, 250};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor of d / 2^k, rounding toward minus infinity.
    function automatic int floor_shr(input int d, input int k);
        if (d >= 0) return d / (1 << k);
        return -(((-d) + (1 << k) - 1) / (1 << k));
    endfunction

    task automatic model_clear();
        foreach (acc_u[i]) acc_u[i] = 0;
        foreach (acc_s[i]) acc_s[i] = 0;
    endtask

    // Drive one cycle of inputs and update the model; returns 1ns after the capturing edge.
    task automatic drive(input logic v, input int ch, input int d, input int k, input logic c);
        int   kk;
        int   x;
        int   ds;
        exp_t e;
        in_valid  = v;
        in_chan   = 2'(ch);
        in_data   = 8'(d);
        shift_sel = 3'(k);
        clr       = c;
        kk = (k > 5) ? 5 : k;
        if (c) begin
            model_clear();
            // A sample about to leave S2 on the clear edge is discarded.
            while (q_u.size() > 0 && q_u[$].due > cyc) void'(q_u.pop_back());
            while (q_s.size() > 0 && q_s[$].due > cyc) void'(q_s.pop_back());
        end else if (v) begin
            x = (d & 255) * 32;
            acc_u[ch] = acc_u[ch] + floor_shr(x - acc_u[ch], kk);
            e.chan = ch;
            e.data = floor_shr(acc_u[ch], 5) & 255;
            e.due  = cyc + 2;
            q_u.push_back(e);
            if (ch < 3) begin
                ds = ((d & 255) >= 128) ? (d & 255) - 256 : (d & 255);
                x  = ds * 32;
                acc_s[ch] = acc_s[ch] + floor_shr(x - acc_s[ch], kk);
                e.data = floor_shr(acc_s[ch], 5) & 255;
                q_s.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic run_seq(input int ch, input int k, input int gap);
        drive(1'b0, 0, 0, 0, 1'b1);
        idle(2);
        logq.delete();
        log_ch = ch;
        log_on = 1'b1;
        foreach (vals[i]) begin
            drive(1'b1, ch, vals[i], k, 1'b0);
            idle(gap);
        end
        idle(3);
        log_on = 1'b0;
    endtask

    // Scoreboard for the unsigned instance.
    always @(negedge clk) begin : mon_u
        exp_t e;
        bit   ev;
        if (rst_n) begin
            ev = (q_u.size() > 0) && (q_u[0].due == cyc);
            check("u_valid", int'(out_valid_u), int'(ev));
            if (ev) begin
                e = q_u.pop_front();
                if (out_valid_u) begin
                    check("u_chan", int'(out_chan_u), e.chan);
                    check("u_data", int'(out_data_u), e.data);
                    if (e.chan == 1 && mono_mode == 1) check("u_mono_up", int'(int'(out_data_u) >= last1), 1);
                    if (e.chan == 1 && mono_mode == 2) check("u_mono_dn", int'(int'(out_data_u) <= last1), 1);
                    if (e.chan == 1) last1 = int'(out_data_u);
                    if (log_on && e.chan == log_ch) logq.push_back(int'(out_data_u));
                end
            end
        end
    end

    // Scoreboard for the signed 3-channel instance.
    always @(negedge clk) begin : mon_s
        exp_t e;
        bit   ev;
        if (rst_n) begin
            ev = (q_s.size() > 0) && (q_s[0].due == cyc);
            check("s_valid", int'(out_valid_s), int'(ev));
            if (ev) begin
                e = q_s.pop_front();
                if (out_valid_s) begin
                    check("s_chan", int'(out_chan_s), e.chan);
                    check("s_data", int'(out_data_s), e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        mono_mode = 0; last1 = 0; log_on = 1'b0; log_ch = 0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_chan = '0; in_data = '0; shift_sel = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_u", int'(out_valid_u), 0);
        check("rst_data_u", int'(out_data_u), 0);
        check("rst_chan_u", int'(out_chan_u), 0);
        check("rst_valid_s", int'(out_valid_s), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mid-stream reset drops everything in flight.
        drive(1'b1, 0, 11, 2, 1'b0);
        drive(1'b1, 1, 22, 3, 1'b0);
        drive(1'b1, 0, 33, 2, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid_u), 0);
        check("mid_rst_data", int'(out_data_u), 0);
        check("mid_rst_chan", int'(out_chan_u), 0);
        check("mid_rst_data_s", int'(out_data_s), 0);
        q_u.delete(); q_s.delete(); model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass at k=0.
        drive(1'b1, 0, 0, 0, 1'b0);
        drive(1'b1, 0, 37, 0, 1'b0);
        drive(1'b1, 0, 255, 0, 1'b0);
        idle(1);
        @(negedge clk);
        check("bypass_last", int'(out_data_u), 255);
        #1;
        idle(2);

        // Unsigned step up then decay on channel 1.
        drive(1'b1, 1, 255, 5, 1'b0);
        idle(1);
        @(negedge clk);
        check("step_first", int'(out_data_u), 7);
        #1;
        mono_mode = 1;
        repeat (299) drive(1'b1, 1, 255, 5, 1'b0);
        idle(3);
        check("step_settle", int'(int'(out_data_u) >= 254), 1);
        mono_mode = 2;
        repeat (300) drive(1'b1, 1, 0, 5, 1'b0);
        idle(3);
        check("decay_zero", int'(out_data_u), 0);
        mono_mode = 0;

        // Signed step on channel 2.
        drive(1'b1, 2, 8'h80, 5, 1'b0);
        idle(1);
        @(negedge clk);
        check("s_step_first", int'(out_data_s), 8'hFC);
        #1;
        repeat (299) drive(1'b1, 2, 8'h80, 5, 1'b0);
        idle(3);
        check("s_settle_neg", int'(out_data_s), 8'h80);
        repeat (300) drive(1'b1, 2, 127, 5, 1'b0);
        idle(3);
        check("s_settle_pos", int'(int'($signed(out_data_s)) >= 126), 1);

        // Channel interleave.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 0, 255, 5, 1'b0);
            drive(1'b1, 1, 0, 5, 1'b0);
        end
        idle(3);

        // Back-to-back on channel 3 must equal the spaced-out run.
        run_seq(3, 2, 0);
        ref_q = logq;
        run_seq(3, 2, 3);
        check("fwd_count", logq.size(), 10);
        for (int i = 0; i < 10 && i < logq.size() && i < ref_q.size(); i++) check("fwd_match", logq[i], ref_q[i]);

        // Shift clamp: shift_sel=7 behaves as 5.
        run_seq(0, 5, 0);
        ref_q = logq;
        run_seq(0, 7, 0);
        check("clamp_count", logq.size(), 10);
        for (int i = 0; i < 10 && i < logq.size() && i < ref_q.size(); i++) check("clamp_match", logq[i], ref_q[i]);

        // Clear with a coincident valid sample.
        repeat (200) drive(1'b1, 1, 255, 5, 1'b0);
        drive(1'b1, 1, 255, 5, 1'b1);
        idle(2);
        drive(1'b1, 1, 255, 5, 1'b0);
        idle(1);
        @(negedge clk);
        check("clr_first", int'(out_data_u), 7);
        #1;

        // Out-of-range channel on the 3-channel instance, then prove its state held.
        drive(1'b1, 2, 100, 3, 1'b0);
        drive(1'b1, 3, 255, 0, 1'b0);
        drive(1'b1, 3, 7, 1, 1'b0);
        drive(1'b1, 2, 100, 3, 1'b0);
        idle(5);

        check("drain_u", q_u.size(), 0);
        check("drain_s", q_s.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/small_lpf_mc.md
Name: small_lpf_mc

Overview:
- Multi-channel, time-multiplexed single-pole IIR low-pass filter. Successor to the single-channel small LPF.
- Adds: per-sample channel tag, signed/unsigned mode, runtime-selectable filter shift, valid handshake, same-channel forwarding and a global clear.
- Sits after ADC/decimator front ends, where several slow channels share one datapath.

Parameters:
- WIDTH, 8, sample width in bits.
- FILT_BITS, 5, maximum filter shift; also the number of fractional accumulator bits.
- CHANNELS, 4, number of independent filter states (≥1).
- SIGNED, 0, 0 = unsigned two's-complement-free data, 1 = signed data with arithmetic shifts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all channel states; takes priority over in_valid.
- in_valid  in  1  input sample qualifier.
- in_chan  in  max(1,$clog2(CHANNELS))  channel of in_data.
- in_data  in  WIDTH  input sample.
- shift_sel  in  $clog2(FILT_BITS+1)  filter shift k, sampled with in_valid; values >FILT_BITS are clamped to FILT_BITS.
- out_valid  out  1  output qualifier.
- out_chan  out  same as in_chan  channel of out_data.
- out_data  out  WIDTH  filtered sample.

Behaviour:
- Reset and state:
  - rst_n low clears all accumulators, pipeline registers, out_valid, out_chan and out_data to 0 immediately.
  - Reset mid-operation drops in-flight samples.
- Accumulator:
  - Per channel, width A = WIDTH+FILT_BITS+1 (sign/guard bit).
  - Scaled input X = in_data << FILT_BITS, sign-extended if SIGNED, zero-extended otherwise.
- Update: acc_new = acc + ((X - acc) >>> k).
  - The arithmetic shift floors toward −inf.
  - Unsigned results never exceed the full-scale X, so no saturation logic is required.
- Output: out_data = acc_new[FILT_BITS +: WIDTH], truncation, no rounding.
  - k=0 gives a bypass: out_data = in_data.
- Pipeline, 2 cycles:
  - S1 registers in_data, in_chan and the clamped k, and reads acc[in_chan].
  - S2 computes acc_new, writes acc[chan], and registers out_valid, out_chan and out_data.
  - out_valid rises exactly 2 clocks after the accepted in_valid.
  - No backpressure. in_valid is accepted every cycle.
- Forwarding: if S1 reads channel c in the same cycle S2 writes channel c, S1 uses the S2 result. Back-to-back samples on one channel therefore give results identical to spacing them apart.
- clr:
  - In cycle n, zeroes all accumulators at the edge.
  - Invalidates both pipeline stages, so out_valid = 0 for the following 2 cycles.
  - An in_valid coincident with clr is discarded.
- Invalid samples (in_valid=0) do not modify any state.
- in_chan ≥ CHANNELS: the sample is dropped, no out_valid, no state change.
- Idle channels hold state indefinitely.

Test Plan:
- Reset/bypass:
  - Stimulus: WIDTH=8, SIGNED=0. Assert rst_n low mid-stream, then release. Feed k=0, chan 0, values 0, 37, 255 in consecutive cycles.
  - Required: all outputs 0 during reset; out_valid 2 cycles after each input; out_data 0, 37, 255; out_chan 0.
- Unsigned step:
  - Stimulus: k=5, chan 1, in_data 255 every cycle.
  - Required: first out_data = 7 (acc 255).
  - Required: output monotonic non-decreasing, reaches ≥254 within 300 samples, never exceeds 255.
  - Required: then in_data 0 decays monotonically to 0.
- Signed step:
  - Stimulus: SIGNED=1, k=5, chan 2, in_data −128 every cycle.
  - Required: first out_data = −4 (acc −128); settles exactly to −128 and holds.
  - Required: then +127 settles to ≥126.
- Channel interleave and forwarding:
  - Stimulus: alternate chan 0/1 with 255/0 each cycle, then 10 back-to-back samples on chan 3.
  - Required: chan 0 and chan 1 trajectories match isolated single-channel runs bit-exactly.
  - Required: the chan 3 results match the same sequence fed with 3 idle cycles between samples.
- clr and invalid channel:
  - Stimulus: after settling chan 1 at 254, pulse clr with in_valid=1.
  - Required: no out_valid for 2 cycles; next chan 1 sample 255 at k=5 yields 7.
  - Stimulus: in_chan = CHANNELS with CHANNELS=3.
  - Required: no out_valid and no state change.
- Shift clamp:
  - Stimulus: shift_sel=7 with FILT_BITS=5.
  - Required: output identical to shift_sel=5.
